// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequential signed radix-2 Booth multiplier with start/busy/done handshake
module booth_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // A carries one guard bit so A-M cannot overflow for the most negative M
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;

    logic             load;
    logic             step;
    logic             last_step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;

    // state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and step/load decode; flush beats the step, start beats flush in DONE
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (count == CW'(1)) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign last_step = step && (count == CW'(1));

    // Booth recode of {Q[0], q_1}: 10 subtracts M, 01 adds M, otherwise hold
    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b10:   sum = a - m;
            2'b01:   sum = a + m;
            default: sum = a;
        endcase
    end

    // arithmetic right shift of {A, Q, q_1} with the A sign bit replicated
    assign a_sh = {sum[WIDTH], sum[WIDTH:1]};
    assign q_sh = {sum[0], q[WIDTH-1:1]};

    // datapath registers; the result registers only change on the final step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            a     <= '0;
            q     <= mplier;
            q_1   <= 1'b0;
            m     <= {mcand[WIDTH-1], mcand};
            count <= CW'(WIDTH);
        end else if (step) begin
            a     <= a_sh;
            q     <= q_sh;
            q_1   <= q[0];
            count <= count - CW'(1);
            if (last_step) begin
                hi <= a_sh[WIDTH-1:0];
                lo <= q_sh;
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - scoreboard bench for booth_seq_ctrl against a signed-multiply model
module tb_booth_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         flush;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_count = 0;
    int last_done_cyc = 0;

    logic [2*W-1:0] exp_q[$];

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .flush  (flush),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {hi, lo}, '0);
                if ({hi, lo} == '0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end
            end else begin
                chk("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_it);
        @(negedge clk);
        start  = 1'b1;
        mcand  = x;
        mplier = y;
        if (expect_it) exp_q.push_back(model(x, y));
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    // waits for done; counts busy cycles seen on the way
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        if (!seen) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int bc;
        issue(x, y, 1'b1);
        wait_done("run_op", bc);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        int dc0;
        int first_done;
        logic [2*W-1:0] prev;

        clr = 1'b1; start = 1'b0; flush = 1'b0; mcand = '0; mplier = '0;
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        // 1: small signed product and busy length
        issue(32'd3, -32'sd7, 1'b1);
        wait_done("t1", bc);
        chk("t1_busy_cycles", 64'(bc), 64'd32);
        chk("t1_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        @(negedge clk);
        chk("t1_idle_after_done", {62'd0, busy, done}, 64'd0);

        // 2: corner operands
        run_op(32'h8000_0000, 32'h8000_0000);
        chk("t2_min_sq", {hi, lo}, {32'h4000_0000, 32'h0});
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2_m1_sq", {hi, lo}, {32'h0, 32'h1});

        // 3: start during RUN is ignored
        dc0 = done_count;
        issue(32'd1000, 32'd77, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; mcand = 32'd5; mplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3", bc);
        repeat (40) @(negedge clk);
        chk("t3_hilo", {hi, lo}, model(32'd1000, 32'd77));
        chk("t3_one_done", 64'(done_count - dc0), 64'd1);

        // 4: flush mid-RUN
        prev = {hi, lo};
        dc0 = done_count;
        issue(32'd123, 32'd456, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_busy_after_flush", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("t4_no_done", 64'(done_count - dc0), 64'd0);
        chk("t4_hilo_kept", {hi, lo}, prev);

        // 5: asynchronous clear mid-RUN
        issue(32'd999, 32'd888, 1'b0);
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        run_op(32'hFFFF_FF00, 32'd3);
        chk("t5_after_clr", {hi, lo}, model(32'hFFFF_FF00, 32'd3));

        // 6: back-to-back issue by holding start through DONE
        @(negedge clk);
        start = 1'b1; mcand = 32'd77; mplier = 32'd88;
        exp_q.push_back(model(32'd77, 32'd88));
        wait_done("t6a", bc);
        first_done = cyc;
        mcand = 32'd12345; mplier = -32'sd678;
        exp_q.push_back(model(32'd12345, -32'sd678));
        @(negedge clk);
        start = 1'b0;
        wait_done("t6b", bc);
        chk("t6_interval", 64'(cyc - first_done), 64'd33);
        chk("t6_hilo", {hi, lo}, 64'(-64'sd8369910));
        @(negedge clk);

        // random signed pairs
        for (int i = 0; i < 1000; i++) begin
            run_op(pick(), pick());
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
